sdram_arbit: RTL and testbench

Command-bus arbiter and refresh scheduler for the SDRAM controller. It sequences power-up initialisation, periodic auto-refresh, and the write and read engines (`sdram_write`, `sdram_read`) onto the single SDRAM command/address bus. It grants the bus to one engine at a time with fixed priority and tells active engines when a refresh is due so they can break their bursts. It sits between the engines and the SDRAM pins; the DQ datapath stays in the engines.

---
 rtl/sdram_arbit.sv | 155 +++++++++++++++
 tb/tb_sdram_arbit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: sequences init, periodic auto-refresh and the
// write/read engines onto one registered command/address bus.
module sdram_arbit #(
  parameter int unsigned REF_PERIOD = 750,
  parameter int unsigned T_RC       = 7
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        flag_init_end,
  input  logic        wr_req,
  output logic        wr_en,
  input  logic        flag_wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank_addr,
  input  logic        rd_req,
  output logic        rd_en,
  input  logic        flag_rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank_addr,
  output logic        ref_req,
  output logic        ref_overrun,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_bank,
  output logic [11:0] sdram_addr
);

  localparam int unsigned ACW = (T_RC < 2) ? 1 : $clog2(T_RC + 1);

  localparam logic [4:0] S_INIT  = 5'b00001;
  localparam logic [4:0] S_ARBIT = 5'b00010;
  localparam logic [4:0] S_AREF  = 5'b00100;
  localparam logic [4:0] S_WRITE = 5'b01000;
  localparam logic [4:0] S_READ  = 5'b10000;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  localparam logic [10:0]    REF_LAST  = 11'(REF_PERIOD - 1);
  localparam logic [ACW-1:0] AREF_LAST = ACW'(T_RC);

  logic [4:0]     state_q, state_d;
  logic [ACW-1:0] aref_cnt_q, aref_cnt_d;
  logic [10:0]    ref_cnt_q, ref_cnt_d;
  logic           init_done_q, init_done_d;
  logic           ref_req_q, ref_req_d;
  logic           overrun_q, overrun_d;
  logic [3:0]     cmd_q, cmd_d;
  logic [11:0]    addr_q, addr_d;
  logic [1:0]     bank_q, bank_d;
  logic           cke_q;

  logic aref_issue;
  logic ref_wrap;

  assign aref_issue = (state_q == S_AREF) && (aref_cnt_q == '0);
  assign ref_wrap   = init_done_q && (ref_cnt_q == REF_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (flag_init_end) state_d = S_ARBIT;
      S_ARBIT: begin
        if (ref_req_q)   state_d = S_AREF;
        else if (wr_req) state_d = S_WRITE;
        else if (rd_req) state_d = S_READ;
      end
      S_AREF:  if (aref_cnt_q == AREF_LAST) state_d = S_ARBIT;
      S_WRITE: if (flag_wr_end) state_d = S_ARBIT;
      S_READ:  if (flag_rd_end) state_d = S_ARBIT;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    aref_cnt_d = '0;
    if (state_q == S_AREF && aref_cnt_q != AREF_LAST) aref_cnt_d = aref_cnt_q + 1'b1;

    init_done_d = init_done_q | ((state_q == S_INIT) && flag_init_end);

    ref_cnt_d = '0;
    if (init_done_q && !ref_wrap) ref_cnt_d = ref_cnt_q + 11'd1;

    // A wrap coinciding with the AREF issue keeps the request pending.
    ref_req_d = ref_wrap | (ref_req_q & ~aref_issue);
    overrun_d = overrun_q | (ref_wrap & ref_req_q);
  end

  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '0;
    bank_d = '0;
    case (state_q)
      S_INIT: begin
        cmd_d  = init_cmd;
        addr_d = init_addr;
      end
      S_AREF: if (aref_issue) cmd_d = CMD_AREF;
      S_WRITE: begin
        cmd_d  = wr_cmd;
        addr_d = wr_addr;
        bank_d = wr_bank_addr;
      end
      S_READ: begin
        cmd_d  = rd_cmd;
        addr_d = rd_addr;
        bank_d = rd_bank_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_INIT;
      aref_cnt_q  <= '0;
      ref_cnt_q   <= '0;
      init_done_q <= 1'b0;
      ref_req_q   <= 1'b0;
      overrun_q   <= 1'b0;
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
      bank_q      <= '0;
      cke_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      aref_cnt_q  <= aref_cnt_d;
      ref_cnt_q   <= ref_cnt_d;
      init_done_q <= init_done_d;
      ref_req_q   <= ref_req_d;
      overrun_q   <= overrun_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      bank_q      <= bank_d;
      cke_q       <= 1'b1;
    end
  end

  assign wr_en       = (state_q == S_WRITE);
  assign rd_en       = (state_q == S_READ);
  assign ref_req     = ref_req_q;
  assign ref_overrun = overrun_q;
  assign sdram_cke   = cke_q;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
  assign sdram_bank  = bank_q;
  assign sdram_addr  = addr_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit with REF_PERIOD=20, T_RC=7; edge numbers
// below (E<n>) count rising edges after the one that samples flag_init_end.
module tb_sdram_arbit;

  logic        sclk = 1'b0;
  logic        reset;
  logic [3:0]  init_cmd;
  logic [11:0] init_addr;
  logic        flag_init_end;
  logic        wr_req, wr_en, flag_wr_end;
  logic [3:0]  wr_cmd;
  logic [11:0] wr_addr;
  logic [1:0]  wr_bank_addr;
  logic        rd_req, rd_en, flag_rd_end;
  logic [3:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  rd_bank_addr;
  logic        ref_req, ref_overrun;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_bank;
  logic [11:0] sdram_addr;
  logic [3:0]  pins;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned n_aref;

  localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, AREF = 4'b0001,
                         ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;

  sdram_arbit #(.REF_PERIOD(20), .T_RC(7)) dut (
    .sclk(sclk), .reset(reset),
    .init_cmd(init_cmd), .init_addr(init_addr), .flag_init_end(flag_init_end),
    .wr_req(wr_req), .wr_en(wr_en), .flag_wr_end(flag_wr_end),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank_addr(wr_bank_addr),
    .rd_req(rd_req), .rd_en(rd_en), .flag_rd_end(flag_rd_end),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank_addr(rd_bank_addr),
    .ref_req(ref_req), .ref_overrun(ref_overrun),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_bank(sdram_bank), .sdram_addr(sdram_addr)
  );

  always #5 sclk = ~sclk;
  assign pins = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    @(negedge sclk);
  endtask

  initial begin
    reset = 1'b0;
    init_cmd = NOP; init_addr = '0; flag_init_end = 1'b0;
    wr_req = 1'b0; flag_wr_end = 1'b0; wr_cmd = NOP; wr_addr = '0; wr_bank_addr = '0;
    rd_req = 1'b0; flag_rd_end = 1'b0; rd_cmd = NOP; rd_addr = '0; rd_bank_addr = '0;
    repeat (3) @(negedge sclk);

    check("rst_cmd", pins, NOP);
    check("rst_cke", sdram_cke, 1'b0);
    check("rst_addr", sdram_addr, 12'h000);
    check("rst_bank", sdram_bank, 2'd0);
    check("rst_ref_req", ref_req, 1'b0);
    check("rst_overrun", ref_overrun, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);

    // Init engine drives PRE, AREF, ACT; pins follow one cycle late.
    reset = 1'b1;
    init_cmd = PRE; init_addr = 12'h400;
    tick();
    check("cke_up", sdram_cke, 1'b1);
    check("init_pre_cmd", pins, PRE);
    check("init_pre_addr", sdram_addr, 12'h400);
    init_cmd = AREF; init_addr = 12'h000;
    tick();
    check("init_aref_cmd", pins, AREF);
    init_cmd = ACT; init_addr = 12'h123; flag_init_end = 1'b1;
    tick(); // E0
    check("init_act_cmd", pins, ACT);
    check("init_act_addr", sdram_addr, 12'h123);
    flag_init_end = 1'b0; init_cmd = PRE; init_addr = 12'h7FF;
    tick(); // E1: now in S_ARBIT, init bus no longer forwarded
    check("arbit_nop", pins, NOP);
    check("arbit_addr", sdram_addr, 12'h000);

    // Idle refresh
    for (int i = 2; i <= 19; i++) begin
      tick();
      check("ref_req_early", ref_req, 1'b0);
    end
    tick(); // E20
    check("ref_req_rise1", ref_req, 1'b1);
    tick(); // E21
    check("ref_req_held", ref_req, 1'b1);
    check("pre_aref_nop", pins, NOP);
    tick(); // E22
    check("aref_on_pins", pins, AREF);
    check("ref_req_clr", ref_req, 1'b0);
    n_aref = 0;
    for (int i = 23; i <= 39; i++) begin
      tick();
      if (pins == AREF) n_aref++;
    end
    check("aref_single", n_aref, 0);
    check("ref_req_gap", ref_req, 1'b0);
    tick(); // E40
    check("ref_req_rise2", ref_req, 1'b1);
    check("overrun_idle", ref_overrun, 1'b0);
    tick(); // E41
    tick(); // E42
    check("aref2_on_pins", pins, AREF);

    // Requests raised during refresh: granted only after 8-cycle S_AREF, write first
    wr_req = 1'b1; rd_req = 1'b1;
    wr_cmd = ACT; wr_addr = 12'h0AB; wr_bank_addr = 2'd2;
    for (int i = 43; i <= 49; i++) begin
      tick();
      check("aref_hold_wr_en", wr_en, 1'b0);
    end
    tick(); // E50
    check("prio_wr_en", wr_en, 1'b1);
    check("prio_rd_en", rd_en, 1'b0);
    check("grant_cycle_nop", pins, NOP);
    tick(); // E51
    check("wr_act_cmd", pins, ACT);
    check("wr_act_addr", sdram_addr, 12'h0AB);
    check("wr_act_bank", sdram_bank, 2'd2);
    wr_cmd = WR; wr_addr = 12'h055;
    tick(); // E52
    check("wr_wr_cmd", pins, WR);
    check("wr_wr_addr", sdram_addr, 12'h055);
    wr_cmd = PRE; wr_addr = 12'h400; flag_wr_end = 1'b1; wr_req = 1'b0;
    tick(); // E53
    check("wr_pre_cmd", pins, PRE);
    check("release_wr_en", wr_en, 1'b0);
    check("release_rd_en", rd_en, 1'b0);
    flag_wr_end = 1'b0;
    rd_cmd = RD; rd_addr = 12'h1F0; rd_bank_addr = 2'd1;
    tick(); // E54
    check("rd_grant", rd_en, 1'b1);
    tick(); // E55
    check("rd_cmd_fwd", pins, RD);
    check("rd_addr_fwd", sdram_addr, 12'h1F0);
    check("rd_bank_fwd", sdram_bank, 2'd1);
    flag_rd_end = 1'b1; wr_req = 1'b1;
    tick(); // E56
    check("rd_release", rd_en, 1'b0);
    check("rd_release_wr", wr_en, 1'b0);
    flag_rd_end = 1'b0;
    wr_cmd = WR; wr_addr = 12'h300; wr_bank_addr = 2'd3;
    tick(); // E57
    check("wr_regrant", wr_en, 1'b1);
    tick(); // E58
    check("wr_fwd_bank", sdram_bank, 2'd3);
    tick(); // E59
    check("ref_req_pre3", ref_req, 1'b0);

    // Refresh break: ref_req rises mid-write, engine ends 5 cycles later
    tick(); // E60
    check("ref_req_rise3", ref_req, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      wr_addr = 12'h300 + 12'(k);
      if (k == 5) flag_wr_end = 1'b1;
      tick();
      check("brk_wr_cmd", pins, WR);
      check("brk_wr_addr", sdram_addr, 12'h300 + 12'(k));
      check("brk_wr_en", wr_en, (k < 5) ? 1'b1 : 1'b0);
    end
    flag_wr_end = 1'b0;
    tick(); // E66
    check("brk_arbit_nop", pins, NOP);
    check("brk_rd_en", rd_en, 1'b0);
    check("brk_ref_pending", ref_req, 1'b1);
    tick(); // E67
    check("brk_aref", pins, AREF);
    check("brk_ref_clr", ref_req, 1'b0);
    for (int i = 68; i <= 74; i++) begin
      tick();
      check("brk_hold", {wr_en, rd_en}, 2'b00);
    end
    tick(); // E75
    check("brk_wr_resume", wr_en, 1'b1);
    check("brk_rd_wait", rd_en, 1'b0);

    // Overrun: write held with no end flag across two wraps
    repeat (4) tick(); // E79
    check("ovr_ref_pre", ref_req, 1'b0);
    tick(); // E80
    check("ovr_ref_rise", ref_req, 1'b1);
    repeat (19) tick(); // E99
    check("ovr_not_yet", ref_overrun, 1'b0);
    check("ovr_wr_held", wr_en, 1'b1);
    tick(); // E100
    check("ovr_set", ref_overrun, 1'b1);
    check("ovr_ref_still", ref_req, 1'b1);
    flag_wr_end = 1'b1; wr_req = 1'b0;
    tick(); // E101
    check("ovr_wr_release", wr_en, 1'b0);
    flag_wr_end = 1'b0;
    tick(); // E102
    tick(); // E103
    check("ovr_aref", pins, AREF);
    check("ovr_ref_clr", ref_req, 1'b0);
    check("ovr_sticky", ref_overrun, 1'b1);
    rd_cmd = RD; rd_addr = 12'h2AA; rd_bank_addr = 2'd0;
    repeat (7) tick(); // E110
    check("ovr_rd_wait", rd_en, 1'b0);
    tick(); // E111
    check("rd2_grant", rd_en, 1'b1);
    repeat (9) tick(); // E120
    check("rd2_ref_req", ref_req, 1'b1);
    check("rd2_cmd", pins, RD);
    check("rd2_overrun", ref_overrun, 1'b1);

    // Asynchronous reset mid-read
    #2 reset = 1'b0;
    #1;
    check("mid_rst_rd_en", rd_en, 1'b0);
    check("mid_rst_ref_req", ref_req, 1'b0);
    check("mid_rst_cmd", pins, NOP);
    check("mid_rst_cke", sdram_cke, 1'b0);
    check("mid_rst_overrun", ref_overrun, 1'b0);
    check("mid_rst_addr", sdram_addr, 12'h000);
    @(negedge sclk);
    reset = 1'b1;
    init_cmd = NOP; init_addr = '0;
    n_aref = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ref_req || rd_en) n_aref++;
    end
    check("no_timer_before_init", n_aref, 0);
    rd_req = 1'b0;
    flag_init_end = 1'b1;
    tick(); // new E0
    flag_init_end = 1'b0;
    repeat (19) tick();
    check("reinit_ref_pre", ref_req, 1'b0);
    tick();
    check("reinit_ref_rise", ref_req, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
